// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ==== pwm_capture : measures period and active time of a PWM pin in ticks  (rev 1.0) ====
// 1 tick = WAVE_WEIGHT clk; reports via valid strobe, flags constant-level inputs as stuck.
module pwm_capture #(
    parameter int WAVE_WEIGHT    = 10,
    parameter int WAVE_LEN_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      active_high,
    input  logic                      pwm_in,
    output logic [WAVE_LEN_WIDTH-1:0] wave_length_out,
    output logic [WAVE_LEN_WIDTH-1:0] pulse_width_out,
    output logic                      active_high_out,
    output logic                      valid,
    output logic                      stuck,
    output logic                      stuck_active
);
    localparam int W  = WAVE_LEN_WIDTH;
    localparam int PW = $clog2(WAVE_WEIGHT);
    localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
    localparam logic [PW-1:0] PRE_LAST = PW'(WAVE_WEIGHT - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(WAVE_WEIGHT / 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        ACTIVE   = 2'd2,
        INACTIVE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, sync_prev;
    logic [PW-1:0] pre, pre_nxt;
    logic [W-1:0]  per_cnt, per_nxt, act_cnt, act_nxt;
    logic [W-1:0]  wave_nxt, pulse_nxt;
    logic          ah_nxt, valid_nxt, stuck_nxt, stuck_active_nxt;
    logic          lvl, lvl_prev, rise, fall, tick, half, do_timeout;
    logic [W-1:0]  per_tick, act_tick, per_rnd, act_rnd;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= pwm_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Both levels use the latched polarity, so a polarity change never fakes an edge.
    assign lvl      = (sync2 == active_high_out);
    assign lvl_prev = (sync_prev == active_high_out);
    assign rise     = lvl & ~lvl_prev;
    assign fall     = ~lvl & lvl_prev;
    assign tick     = (pre == PRE_LAST) && !(rise || fall);
    assign half     = (pre >= PRE_HALF);
    assign per_tick = sat_inc(per_cnt, tick);
    assign act_tick = sat_inc(act_cnt, tick);
    assign per_rnd  = sat_inc(per_cnt, half);
    assign act_rnd  = sat_inc(act_cnt, half);

    always_comb begin
        state_nxt        = state;
        pre_nxt          = (tick || rise || fall) ? '0 : pre + PW'(1);
        per_nxt          = per_tick;
        act_nxt          = act_cnt;
        wave_nxt         = wave_length_out;
        pulse_nxt        = pulse_width_out;
        ah_nxt           = active_high_out;
        valid_nxt        = 1'b0;
        stuck_nxt        = stuck;
        stuck_active_nxt = stuck_active;
        do_timeout       = 1'b0;

        if (state != IDLE && !enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    pre_nxt = '0;
                    per_nxt = per_cnt;
                    if (enable) begin
                        ah_nxt    = active_high;
                        per_nxt   = '0;
                        act_nxt   = '0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (rise) begin
                        per_nxt   = '0;
                        act_nxt   = '0;
                        state_nxt = ACTIVE;
                    end else if (fall) begin
                        per_nxt = per_rnd;
                    end else if (per_cnt == CNT_MAX) begin
                        do_timeout = 1'b1;
                    end
                end
                ACTIVE: begin
                    act_nxt = act_tick;
                    if (fall) begin
                        act_nxt   = act_rnd;
                        per_nxt   = per_rnd;
                        state_nxt = INACTIVE;
                    end else if (per_cnt == CNT_MAX) begin
                        do_timeout = 1'b1;
                    end
                end
                INACTIVE: begin
                    if (rise) begin
                        wave_nxt  = per_rnd;
                        pulse_nxt = act_cnt;
                        valid_nxt = 1'b1;
                        stuck_nxt = 1'b0;
                        per_nxt   = '0;
                        act_nxt   = '0;
                        state_nxt = ACTIVE;
                    end else if (per_cnt == CNT_MAX) begin
                        do_timeout = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Only the first timeout of a stuck episode is announced with valid.
        if (do_timeout) begin
            wave_nxt         = '0;
            pulse_nxt        = '0;
            valid_nxt        = ~stuck;
            stuck_nxt        = 1'b1;
            stuck_active_nxt = lvl;
            pre_nxt          = '0;
            per_nxt          = '0;
            act_nxt          = '0;
            state_nxt        = SYNC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre             <= '0;
            per_cnt         <= '0;
            act_cnt         <= '0;
            wave_length_out <= '0;
            pulse_width_out <= '0;
            active_high_out <= 1'b0;
            valid           <= 1'b0;
            stuck           <= 1'b0;
            stuck_active    <= 1'b0;
        end else begin
            pre             <= pre_nxt;
            per_cnt         <= per_nxt;
            act_cnt         <= act_nxt;
            wave_length_out <= wave_nxt;
            pulse_width_out <= pulse_nxt;
            active_high_out <= ah_nxt;
            valid           <= valid_nxt;
            stuck           <= stuck_nxt;
            stuck_active    <= stuck_active_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_pwm_capture : directed PWM waveforms checked against a tick-arithmetic model  (rev 1.0) ====
module tb_pwm_capture;
    localparam int WW   = 10;
    localparam int W    = 8;
    localparam int MAXC = 255;

    logic         clk = 1'b0;
    logic         reset, enable, active_high, pwm_in;
    logic [W-1:0] wave_length_out, pulse_width_out;
    logic         active_high_out, valid, stuck, stuck_active;

    int checks = 0;
    int failures = 0;
    int gen_per = 10;
    int gen_wid = 5;
    bit gen_inv = 1'b0;

    pwm_capture #(.WAVE_WEIGHT(WW), .WAVE_LEN_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .active_high(active_high), .pwm_in(pwm_in),
        .wave_length_out(wave_length_out), .pulse_width_out(pulse_width_out),
        .active_high_out(active_high_out), .valid(valid), .stuck(stuck), .stuck_active(stuck_active)
    );

    always #5 clk = ~clk;

    // PWM source: gen_per ticks per period, first gen_wid ticks high, optionally inverted.
    initial begin : pwm_gen
        int p, a;
        bit inv;
        pwm_in = 1'b0;
        forever begin
            p = gen_per; a = gen_wid; inv = gen_inv;
            for (int k = 0; k < p * WW; k++) begin
                @(posedge clk); #1;
                pwm_in = ((k < a * WW) ? 1'b1 : 1'b0) ^ inv;
            end
        end
    end

    // Reference model: ticks of an interval of x clk since a prescaler restart are
    // floor(x/WW) while running and round-half-up of x/WW when an edge closes it.
    int cyc = 0, seg0 = 0, pbase = 0, abase = 0, m_st = 0;
    int m_wave = 0, m_pulse = 0;
    bit m_ah = 0, m_valid = 0, m_stuck = 0, m_sa = 0;
    bit pin_d1 = 0, pin_d2 = 0, pin_d3 = 0;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    always @(posedge clk) begin : model
        bit lvl, lvl_p, rise, fall, tmo;
        int x, per_now, per_rnd, act_rnd;
        if (!reset) begin
            m_st = 0; seg0 = 0; pbase = 0; abase = 0; m_wave = 0; m_pulse = 0;
            m_ah = 0; m_valid = 0; m_stuck = 0; m_sa = 0;
            pin_d1 = 0; pin_d2 = 0; pin_d3 = 0;
        end else begin
            lvl     = (pin_d2 == m_ah);
            lvl_p   = (pin_d3 == m_ah);
            rise    = lvl && !lvl_p;
            fall    = !lvl && lvl_p;
            x       = cyc - seg0;
            per_now = sat(pbase + x / WW);
            per_rnd = sat(pbase + (x + WW - WW / 2) / WW);
            act_rnd = sat((x + WW - WW / 2) / WW);
            m_valid = 0;
            tmo     = 0;
            if (m_st != 0 && !enable) m_st = 0;
            else case (m_st)
                0: if (enable) begin m_ah = active_high; m_st = 1; pbase = 0; seg0 = cyc + 1; end
                1: if (rise) begin m_st = 2; pbase = 0; seg0 = cyc + 1; end
                   else if (fall) begin pbase = per_rnd; seg0 = cyc + 1; end
                   else if (per_now == MAXC) tmo = 1;
                2: if (fall) begin abase = act_rnd; pbase = per_rnd; seg0 = cyc + 1; m_st = 3; end
                   else if (per_now == MAXC) tmo = 1;
                3: if (rise) begin
                       m_wave = per_rnd; m_pulse = abase; m_valid = 1; m_stuck = 0;
                       m_st = 2; pbase = 0; seg0 = cyc + 1;
                   end else if (per_now == MAXC) tmo = 1;
                default: m_st = 0;
            endcase
            if (tmo) begin
                m_wave = 0; m_pulse = 0; m_valid = !m_stuck; m_stuck = 1; m_sa = lvl;
                m_st = 1; pbase = 0; seg0 = cyc + 1;
            end
            pin_d3 = pin_d2; pin_d2 = pin_d1; pin_d1 = pwm_in;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        logic [2*W+3:0] exp_v, act_v;
        act_v = {wave_length_out, pulse_width_out, active_high_out, valid, stuck, stuck_active};
        if (!reset) exp_v = '0;
        else exp_v = {W'(m_wave), W'(m_pulse), m_ah, m_valid, m_stuck, m_sa};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got wave=%0d pulse=%0d ah=%0b valid=%0b stuck=%0b sa=%0b expected wave=%0d pulse=%0d ah=%0b valid=%0b stuck=%0b sa=%0b",
                     $time, wave_length_out, pulse_width_out, active_high_out, valid, stuck, stuck_active,
                     exp_v[2*W+3:W+4], exp_v[W+3:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_report(input string name, input int ew, input int ep, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (valid && wave_length_out == W'(ew) && pulse_width_out == W'(ep)) got = 1'b1;
        end
        lit({name, "_seen"}, int'(got), 1);
        lit({name, "_stuck"}, int'(stuck), 0);
        lit({name, "_model_wave"}, m_wave, ew);
        lit({name, "_model_pulse"}, m_pulse, ep);
    endtask

    task automatic restart(input bit ah);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        active_high = ah;
        enable = 1'b1;
    endtask

    task automatic first_report_after_sync(input string name, input int ew, input int ep);
        int n;
        bit got;
        n = 0; got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
        end
        lit({name, "_seen"}, int'(got), 1);
        lit({name, "_not_early"}, int'(n >= 100), 1);
        lit({name, "_wave"}, int'(wave_length_out), ew);
        lit({name, "_pulse"}, int'(pulse_width_out), ep);
    endtask

    initial begin : main
        int vc, n;
        bit got;
        reset = 1'b0; enable = 1'b0; active_high = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("reset_outputs", int'({wave_length_out, pulse_width_out, active_high_out, valid, stuck, stuck_active}), 0);
        @(posedge clk); #1;
        reset = 1'b1; enable = 1'b1;

        wait_report("t1_first", 10, 5, 400);
        n = 0; got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
        end
        lit("t1_interval", n, 100);
        wait_report("t1_again", 10, 5, 150);

        gen_per = 20; gen_wid = 18;
        wait_report("t2_20_18", 20, 18, 700);
        gen_per = 5; gen_wid = 1;
        wait_report("t2_5_1", 5, 1, 400);

        gen_wid = 0;
        vc = 0; got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (valid) vc++;
            if (stuck) got = 1'b1;
        end
        lit("t3_stuck_seen", int'(got), 1);
        lit("t3_wave_zero", int'(wave_length_out), 0);
        lit("t3_pulse_zero", int'(pulse_width_out), 0);
        lit("t3_stuck_inactive", int'(stuck_active), 0);
        repeat (3000) begin
            @(negedge clk);
            if (valid) vc++;
        end
        lit("t3_single_valid", vc, 1);

        gen_wid = 5;
        vc = 0; got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            if (valid) vc++;
            if (stuck_active) got = 1'b1;
        end
        lit("t3_stuck_active_seen", int'(got), 1);
        lit("t3_no_more_valid", vc, 0);
        lit("t3_still_stuck", int'(stuck), 1);

        gen_per = 10; gen_wid = 5;
        wait_report("t4_recover", 10, 5, 1500);

        gen_inv = 1'b1;
        restart(1'b0);
        wait_report("t5_al0_5of10", 10, 5, 600);
        restart(1'b1);
        wait_report("t5_ah1_5of10", 10, 5, 600);
        gen_wid = 3;
        wait_report("t5_ah1_7of10", 10, 7, 600);
        restart(1'b0);
        wait_report("t5_al0_3of10", 10, 3, 600);

        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        vc = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid) vc++;
        end
        lit("t6_disabled_valids", vc, 0);
        lit("t6_hold_wave", int'(wave_length_out), 10);
        lit("t6_hold_pulse", int'(pulse_width_out), 3);
        @(posedge clk); #1;
        enable = 1'b1;
        first_report_after_sync("t6_reenable", 10, 3);

        repeat (40) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        lit("t6_reset_zero", int'({wave_length_out, pulse_width_out, active_high_out, valid, stuck, stuck_active}), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        first_report_after_sync("t6_after_reset", 10, 3);
        lit("t6_polarity_relatched", int'(active_high_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #600000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
